// File: rtl/flag_unit_if.sv
// EX-stage to flag-unit bundle: flag-writing instruction info in, committed and
// forwarded N/Z/V plus status out.
interface flag_unit_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              ex_valid;
    logic              ex_stall;
    logic              ex_flush;
    logic              ex_set_N;
    logic              ex_set_Z;
    logic              ex_set_V;
    logic [DATA_W-1:0] ex_result;
    logic              ex_ovfl;
    logic              halt_in;

    logic              N;
    logic              Z;
    logic              V;
    logic              fwd_N;
    logic              fwd_Z;
    logic              fwd_V;
    logic              frozen;
    logic [CNT_W-1:0]  upd_cnt;

    modport master (
        output ex_valid, ex_stall, ex_flush, ex_set_N, ex_set_Z, ex_set_V,
               ex_result, ex_ovfl, halt_in,
        input  N, Z, V, fwd_N, fwd_Z, fwd_V, frozen, upd_cnt
    );

    modport slave (
        input  ex_valid, ex_stall, ex_flush, ex_set_N, ex_set_Z, ex_set_V,
               ex_result, ex_ovfl, halt_in,
        output N, Z, V, fwd_N, fwd_Z, fwd_V, frozen, upd_cnt
    );
endinterface

// File: rtl/flag_unit.sv
// N/Z/V flag producer: one-entry pending slot between EX and the architectural
// flags, per-bit newest-writer forwarding to ID, and a halt freeze.
//
//  state  | meaning
//  RUN    | capturing EX writers, committing the pending slot
//  FROZEN | halted; flags, counter and forwarding held until reset
module flag_unit #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input logic       clk,
    input logic       rst,
    flag_unit_if.slave bus
);
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t           state;
    logic             pend_valid;
    logic [2:0]       pend_set;    // {N, Z, V}
    logic [2:0]       pend_val;    // {N, Z, V}
    logic [2:0]       arch;        // {N, Z, V}
    logic             frozen_q;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       ex_set;
    logic [2:0]       ex_val;
    logic             ex_cand;
    logic [2:0]       fwd;

    assign ex_set = {bus.ex_set_N, bus.ex_set_Z, bus.ex_set_V};
    assign ex_val = {bus.ex_result[DATA_W-1], (bus.ex_result == '0), bus.ex_ovfl};

    assign ex_cand = bus.ex_valid & ~bus.ex_flush & ~bus.ex_stall
                   & (|ex_set) & (state == RUN);

    // Newest writer wins per bit: EX over pending over architectural.
    always_comb begin
        fwd = arch;
        if (state == RUN) begin
            for (int i = 0; i < 3; i++) begin
                if (pend_valid && pend_set[i]) fwd[i] = pend_val[i];
                if (ex_cand && ex_set[i])      fwd[i] = ex_val[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            pend_set   <= 3'b000;
            pend_val   <= 3'b000;
            arch       <= 3'b000;
            frozen_q   <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                RUN: begin
                    // The older pending entry commits even in the halt cycle.
                    if (pend_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            if (pend_set[i]) arch[i] <= pend_val[i];
                        end
                        if (cnt != '1) cnt <= cnt + CNT_W'(1);
                    end

                    if (bus.halt_in) begin
                        state      <= FROZEN;
                        frozen_q   <= 1'b1;
                        pend_valid <= 1'b0;
                    end else begin
                        pend_valid <= ex_cand;
                        if (ex_cand) begin
                            pend_set <= ex_set;
                            pend_val <= ex_val;
                        end
                    end
                end
                FROZEN: begin
                    state    <= FROZEN;
                    frozen_q <= 1'b1;
                end
                default: begin
                    state      <= RUN;
                    frozen_q   <= 1'b0;
                    pend_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.N       = arch[2];
    assign bus.Z       = arch[1];
    assign bus.V       = arch[0];
    assign bus.fwd_N   = fwd[2];
    assign bus.fwd_Z   = fwd[1];
    assign bus.fwd_V   = fwd[0];
    assign bus.frozen  = frozen_q;
    assign bus.upd_cnt = cnt;
endmodule
